// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered 3-to-8 hold decoder.
package dec_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 1 << DEC_IN_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] idx);
    logic [DEC_OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec3to8_hold_onehot_dec.sv
// Pure combinational binary-to-one-hot decoder feeding the output register.
module onehot_dec #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  idx_i,
  output logic [OUT_W-1:0] dec_o
);

  assign dec_o = {{(OUT_W-1){1'b0}}, 1'b1} << idx_i;

endmodule

// File: rtl/dec3to8_hold.sv
// Registered one-hot decoder that holds each code for HOLD cycles, with a
// one-entry pending buffer so back-to-back codes are never dropped.
module dec3to8_hold
  import dec_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = 1 << IN_W,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             V,
  input  logic [IN_W-1:0]  a,
  output logic             in_ready,
  output logic [OUT_W-1:0] d,
  output logic             d_valid,
  output logic             d_start,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d;
  logic [IN_W-1:0]   pend_a_q, pend_a_d;
  logic [OUT_W-1:0]  d_q, d_d;
  logic              d_valid_q, d_valid_d;
  logic              d_start_q, d_start_d;

  logic              take;
  logic              load;
  logic              sel_pend;
  logic [IN_W-1:0]   dec_idx;
  logic [OUT_W-1:0]  dec_val;

  assign in_ready = !rst && (state_q == ST_IDLE || !pend_v_q);
  assign take     = V && in_ready;
  assign dec_idx  = sel_pend ? pend_a_q : a;

  onehot_dec #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .idx_i (dec_idx),
    .dec_o (dec_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_v_d  = pend_v_q;
    pend_a_d  = pend_a_q;
    d_d       = d_q;
    d_valid_d = d_valid_q;
    d_start_d = 1'b0;
    load      = 1'b0;
    sel_pend  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (take) begin
            pend_a_d = a;
            pend_v_d = 1'b1;
          end
        end else if (pend_v_q) begin
          // Pending entry wins over a fresh code; in_ready is low here anyway.
          load     = 1'b1;
          sel_pend = 1'b1;
          pend_v_d = 1'b0;
        end else if (take) begin
          load = 1'b1;
        end else begin
          d_d       = '0;
          d_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      d_d       = dec_val;
      d_valid_d = 1'b1;
      d_start_d = 1'b1;
      cnt_d     = 8'(HOLD - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      pend_v_q  <= 1'b0;
      pend_a_q  <= '0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      d_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_v_q  <= pend_v_d;
      pend_a_q  <= pend_a_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      d_start_q <= d_start_d;
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign d_start = d_start_q;
  assign busy    = (state_q == ST_HOLD) || pend_v_q;

endmodule

// File: tb/tb_dec3to8_hold.sv
// Directed bench for dec3to8_hold: three instances with HOLD = 4, 1 and 2.
module tb_dec3to8_hold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: HOLD=4
  logic       rst_a, v_a;
  logic [2:0] a_a;
  logic       rdy_a, dv_a, ds_a, busy_a;
  logic [7:0] d_a;

  // Instance B: HOLD=1
  logic       rst_b, v_b;
  logic [2:0] a_b;
  logic       rdy_b, dv_b, ds_b, busy_b;
  logic [7:0] d_b;

  // Instance C: HOLD=2
  logic       rst_c, v_c;
  logic [2:0] a_c;
  logic       rdy_c, dv_c, ds_c, busy_c;
  logic [7:0] d_c;

  dec3to8_hold #(.IN_W(3), .OUT_W(8), .HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .V(v_a), .a(a_a), .in_ready(rdy_a),
    .d(d_a), .d_valid(dv_a), .d_start(ds_a), .busy(busy_a));

  dec3to8_hold #(.IN_W(3), .OUT_W(8), .HOLD(1)) dut_b (
    .clk(clk), .rst(rst_b), .V(v_b), .a(a_b), .in_ready(rdy_b),
    .d(d_b), .d_valid(dv_b), .d_start(ds_b), .busy(busy_b));

  dec3to8_hold #(.IN_W(3), .OUT_W(8), .HOLD(2)) dut_c (
    .clk(clk), .rst(rst_c), .V(v_c), .a(a_c), .in_ready(rdy_c),
    .d(d_c), .d_valid(dv_c), .d_start(ds_c), .busy(busy_c));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ed, input logic es, input logic ev);
    chk({tag, ".d"}, 32'(d_a), 32'(ed));
    chk({tag, ".start"}, 32'(ds_a), 32'(es));
    chk({tag, ".valid"}, 32'(dv_a), 32'(ev));
  endtask

  logic [7:0] walk [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst_a = 1'b1; v_a = 1'b1; a_a = 3'd3;
    rst_b = 1'b1; v_b = 1'b0; a_b = 3'd0;
    rst_c = 1'b1; v_c = 1'b0; a_c = 3'd0;
    step(); step();

    // Reset state with V high
    chk_a("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.in_ready", 32'(rdy_a), 32'd0);
    chk("rst.busy", 32'(busy_a), 32'd0);
    rst_b = 1'b0; rst_c = 1'b0;

    // Single code a=5, HOLD=4
    rst_a = 1'b0; v_a = 1'b1; a_a = 3'd5;
    #1;
    chk("single.in_ready", 32'(rdy_a), 32'd1);
    step();
    v_a = 1'b0;
    chk_a("single.c1", 8'h20, 1'b1, 1'b1);
    chk("single.busy", 32'(busy_a), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_a($sformatf("single.c%0d", i), 8'h20, 1'b0, 1'b1);
    end
    step();
    chk_a("single.idle", 8'h00, 1'b0, 1'b0);
    chk("single.idle_busy", 32'(busy_a), 32'd0);

    // Pending path: 2, 6, then 7 held on V
    v_a = 1'b1; a_a = 3'd2;
    step();
    chk_a("pend.2c1", 8'h04, 1'b1, 1'b1);
    a_a = 3'd6;
    #1;
    chk("pend.rdy_before6", 32'(rdy_a), 32'd1);
    step();
    a_a = 3'd7;
    #1;
    chk("pend.rdy_after6", 32'(rdy_a), 32'd0);
    chk_a("pend.2c2", 8'h04, 1'b0, 1'b1);
    step();
    chk_a("pend.2c3", 8'h04, 1'b0, 1'b1);
    step();
    chk_a("pend.2c4", 8'h04, 1'b0, 1'b1);
    chk("pend.rdy_c4", 32'(rdy_a), 32'd0);
    step();
    chk_a("pend.6c1", 8'h40, 1'b1, 1'b1);
    chk("pend.rdy_reload", 32'(rdy_a), 32'd1);
    step();
    v_a = 1'b0;
    chk_a("pend.6c2", 8'h40, 1'b0, 1'b1);
    chk("pend.rdy_after7", 32'(rdy_a), 32'd0);
    step();
    chk_a("pend.6c3", 8'h40, 1'b0, 1'b1);
    step();
    chk_a("pend.6c4", 8'h40, 1'b0, 1'b1);
    step();
    chk_a("pend.7c1", 8'h80, 1'b1, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_a($sformatf("pend.7c%0d", i), 8'h80, 1'b0, 1'b1);
    end
    step();
    chk_a("pend.idle", 8'h00, 1'b0, 1'b0);

    // Reset during 2nd hold cycle with a pending entry
    v_a = 1'b1; a_a = 3'd1;
    step();
    a_a = 3'd2;
    step();
    chk("mid.busy_pre", 32'(busy_a), 32'd1);
    chk_a("mid.pre", 8'h02, 1'b0, 1'b1);
    v_a = 1'b0; rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk_a("mid.rst", 8'h00, 1'b0, 1'b0);
    chk("mid.busy", 32'(busy_a), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("mid.no_pend%0d", i), 32'(d_a), 32'd0);
    end

    // HOLD=1 stream 0..7
    v_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_b = 3'(i);
      #1;
      chk($sformatf("h1.rdy%0d", i), 32'(rdy_b), 32'd1);
      step();
      chk($sformatf("h1.d%0d", i), 32'(d_b), 32'(walk[i]));
      chk($sformatf("h1.start%0d", i), 32'(ds_b), 32'd1);
    end
    v_b = 1'b0;
    step();
    chk("h1.idle", 32'(d_b), 32'd0);
    chk("h1.idle_valid", 32'(dv_b), 32'd0);

    // HOLD=2 same code twice
    v_c = 1'b1; a_c = 3'd4;
    step();
    chk("h2.c1.d", 32'(d_c), 32'h10);
    chk("h2.c1.start", 32'(ds_c), 32'd1);
    step();
    v_c = 1'b0;
    chk("h2.c2.d", 32'(d_c), 32'h10);
    chk("h2.c2.start", 32'(ds_c), 32'd0);
    step();
    chk("h2.c3.d", 32'(d_c), 32'h10);
    chk("h2.c3.start", 32'(ds_c), 32'd1);
    chk("h2.c3.valid", 32'(dv_c), 32'd1);
    step();
    chk("h2.c4.d", 32'(d_c), 32'h10);
    chk("h2.c4.start", 32'(ds_c), 32'd0);
    step();
    chk("h2.idle", 32'(d_c), 32'd0);
    chk("h2.idle_busy", 32'(busy_c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
